// File: rtl/booth_pkg.sv
// booth_pkg: shared widths and FSM state type for the Booth product accumulator
//   PROD_W_DEF : product width, matches the 4x4 Booth multiplier output Y
//   ACC_W_DEF  : default accumulator/result width
//   LEN_W_DEF  : default frame-length field width
//   acc_state_t: IDLE / ACCUM / DONE
package booth_pkg;
    localparam int PROD_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;
    localparam int LEN_W_DEF  = 4;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} acc_state_t;
endpackage

// File: rtl/booth_acc_add.sv
// booth_acc_add: sign-extend a product, add it to the accumulator, flag signed overflow
//   acc  : current accumulator value (signed, ACC_W)
//   prod : signed product (PROD_W), sign-extended to ACC_W
//   sum  : next accumulator value (wrapped, or clamped when BOOTH_ACC_SAT_EN is defined)
//   ovf  : signed overflow on this addition
// Macro BOOTH_ACC_SAT_EN: saturate to the signed range instead of wrapping.
module booth_acc_add #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);
    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] raw;
    assign ext = ACC_W'($signed(prod));
    assign raw = acc + ext;
    // same-sign addends producing an opposite-sign sum
    assign ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);
`ifdef BOOTH_ACC_SAT_EN
    assign sum = !ovf ? raw : acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
    assign sum = raw;
`endif
endmodule

// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator: sums a programmed number of signed products per frame
//   clk, rst (async, active-high)
//   start, len          : frame start (sampled in IDLE) and product count
//   in_valid, in_ready, prod      : product input stream
//   out_valid, out_ready, acc_out, ovf : frame result stream with overflow flag
// Macro BOOTH_ACC_SAT_EN: accumulator saturates instead of wrapping on overflow.
module booth_product_accumulator
    import booth_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              ovf
);
    acc_state_t       state, state_nxt;
    logic [LEN_W-1:0] remaining;
    logic [ACC_W-1:0] acc, sum;
    logic             add_ovf, fire;

    booth_acc_add #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_add (
        .acc (acc),
        .prod(prod),
        .sum (sum),
        .ovf (add_ovf)
    );

    assign in_ready  = state == ACCUM;
    assign out_valid = state == DONE;
    assign fire      = in_valid && in_ready;
    assign acc_out   = acc;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = !start ? IDLE : (len == '0) ? DONE : ACCUM;
            ACCUM:   state_nxt = (fire && remaining == LEN_W'(1)) ? DONE : ACCUM;
            DONE:    state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            remaining <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
        end else if (state == IDLE && start) begin
            remaining <= len;
            acc       <= '0;
            ovf       <= 1'b0;
        end else if (fire) begin
            remaining <= remaining - LEN_W'(1);
            acc       <= sum;
            ovf       <= ovf | add_ovf;
        end
endmodule

// File: tb/tb_booth_product_accumulator.sv
module tb_booth_product_accumulator;
    localparam int PW = 8;
    localparam int AW = 10;
    localparam int LW = 4;
    typedef logic [15:0][PW-1:0] beats_t;
    typedef struct {
        string  name;
        int     n;
        beats_t p;
        int     gap;
        int     acc;
        int     ovf;
    } vec_t;

    logic          clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
    logic [LW-1:0] len = '0;
    logic [PW-1:0] prod = '0;
    logic          in_ready, out_valid, ovf;
    logic [AW-1:0] acc_out;
    int            total = 0, passed = 0;

    booth_product_accumulator #(.PROD_W(PW), .ACC_W(AW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .prod(prod),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int acc_val();
        return int'($signed(acc_out));
    endfunction

    // Reference: integer running sum with range check on every beat
    function automatic void model(input int n, input beats_t p, output int a, output int o);
        int lo = -(1 << (AW - 1));
        int hi = (1 << (AW - 1)) - 1;
        a = 0;
        o = 0;
        for (int i = 0; i < n; i++) begin
            a += int'($signed(p[i]));
            if (a > hi || a < lo) begin
                o = 1;
`ifdef BOOTH_ACC_SAT_EN
                a = (a > hi) ? hi : lo;
`else
                a = (a > hi) ? a - (1 << AW) : a + (1 << AW);
`endif
            end
        end
    endfunction

    function automatic beats_t pack5(input int a, input int b, input int c, input int d, input int e);
        beats_t r = '0;
        r[0] = PW'(a); r[1] = PW'(b); r[2] = PW'(c); r[3] = PW'(d); r[4] = PW'(e);
        return r;
    endfunction

    task automatic run_frame(input string name, input int n, input beats_t p, input int gap);
        start = 1;
        len = LW'(n);
        @(posedge clk); #1;
        start = 0;
        if (n == 0) begin
            check({name, "_empty_valid"}, out_valid, 1);
            check({name, "_empty_ready"}, in_ready, 0);
        end else check({name, "_accum_ready"}, in_ready, 1);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < (i == 0 ? 0 : gap); g++) begin
                @(posedge clk); #1;
                check({name, "_stall_valid"}, out_valid, 0);
            end
            in_valid = 1;
            prod = p[i];
            @(posedge clk); #1;
            in_valid = 0;
        end
        check({name, "_done_valid"}, out_valid, 1);
        check({name, "_done_ready"}, in_ready, 0);
    endtask

    task automatic take(input string name);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        check({name, "_idle_valid"}, out_valid, 0);
        check({name, "_idle_ready"}, in_ready, 0);
    endtask

    vec_t vecs[4];

    initial begin
        int ea, eo;
        beats_t rp;
        vecs[0] = '{"basic", 3, pack5(4, 12, -12, 0, 0), 0, 4, 0};
        vecs[1] = '{"bubble", 2, pack5(-31, 2, 0, 0, 0), 3, -29, 0};
        vecs[2] = '{"empty", 0, pack5(0, 0, 0, 0, 0), 0, 0, 0};
`ifdef BOOTH_ACC_SAT_EN
        vecs[3] = '{"ovf", 5, pack5(127, 127, 127, 127, 127), 0, 511, 1};
`else
        vecs[3] = '{"ovf", 5, pack5(127, 127, 127, 127, 127), 0, -389, 1};
`endif

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 0);
        check("rst_acc", acc_val(), 0);
        check("rst_ovf", ovf, 0);
        rst = 0;
        @(posedge clk); #1;

        foreach (vecs[k]) begin
            run_frame(vecs[k].name, vecs[k].n, vecs[k].p, vecs[k].gap);
            check({vecs[k].name, "_acc"}, acc_val(), vecs[k].acc);
            check({vecs[k].name, "_ovf"}, ovf, vecs[k].ovf);
            take(vecs[k].name);
        end

        // backpressure in DONE with a start attempt that must be ignored
        run_frame("bp", 2, pack5(-31, 2, 0, 0, 0), 0);
        start = 1;
        len = 4'd7;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_ready", in_ready, 0);
            check("bp_hold_acc", acc_val(), -29);
        end
        start = 0;
        take("bp");

        // asynchronous reset after 2 of 4 beats
        start = 1;
        len = 4'd4;
        @(posedge clk); #1;
        start = 0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1;
            prod = PW'(50);
            @(posedge clk); #1;
        end
        in_valid = 0;
        check("mid_acc_pre", acc_val(), 100);
        #2 rst = 1;
        #1;
        check("mid_rst_acc", acc_val(), 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ovf", ovf, 0);
        @(posedge clk); #1;
        rst = 0;
        run_frame("fresh", 1, pack5(-12, 0, 0, 0, 0), 0);
        check("fresh_acc", acc_val(), -12);
        check("fresh_ovf", ovf, 0);
        take("fresh");

        // randomized frames against the integer model
        for (int f = 0; f < 30; f++) begin
            int n = (f == 0) ? 15 : int'($urandom_range(0, 15));
            for (int i = 0; i < 16; i++)
                rp[i] = (f == 0) ? 8'h80 : PW'($urandom);
            model(n, rp, ea, eo);
            run_frame("rnd", n, rp, int'($urandom_range(0, 2)));
            check("rnd_acc", acc_val(), ea);
            check("rnd_ovf", ovf, eo);
            take("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/booth_product_accumulator.md
# booth_product_accumulator

Sequential accumulation stage directly downstream of the 4x4 Booth multiplier. It consumes the multiplier's 8-bit two's-complement product `Y` as a valid/ready stream and sums a programmed number of products per frame into a wide accumulator. It presents the frame result on a valid/ready output with an overflow flag. It turns the combinational multiplier into a dot-product / MAC datapath.

## Interface
- `PROD_W`, 8: product width; signed two's complement, matches multiplier `Y`.
- `ACC_W`, 16: accumulator and result width; must be ≥ `PROD_W`.
- `LEN_W`, 4: width of the frame-length field; maximum of 2^LEN_W−1 products per frame.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: frame start pulse; sampled only in IDLE.
- `len`, in, LEN_W: number of products in the frame; latched on accepted `start`.
- `in_valid`, in, 1: product beat valid.
- `in_ready`, out, 1: block accepts a product this cycle.
- `prod`, in, PROD_W: signed product from the multiplier.
- `out_valid`, out, 1: frame result valid.
- `out_ready`, in, 1: downstream takes the result.
- `acc_out`, out, ACC_W: signed frame sum.
- `ovf`, out, 1: a signed overflow occurred during this frame.

## Operation
- States: IDLE, ACCUM, DONE.
- **IDLE**: `in_ready`=0, `out_valid`=0.
  - If `start`=1: latch `len` into `remaining`, clear `acc` and `ovf`.
  - If `len`≠0, go to ACCUM. If `len`=0, go to DONE; the result is 0.
- **ACCUM**: `in_ready`=1.
  - A beat is accepted when `in_valid`&`in_ready`.
  - On each accepted beat: sign-extend `prod` to ACC_W, add it to `acc`, and decrement `remaining`.
  - Go to DONE on the beat where `remaining`==1.
  - `in_valid`=0 cycles stall the frame; there is no timeout.
- **DONE**: `out_valid`=1; `acc_out` and `ovf` are held stable.
  - When `out_ready`=1, go to IDLE.
  - `in_ready`=0, so the multiplier is backpressured.
- `start` is ignored outside IDLE.
- `acc_out` continuously reflects `acc`. It is only defined for the consumer while `out_valid`=1.
- Overflow: `ovf` is set, and stays set for the rest of the frame, when the two addends have the same sign and the sum's sign differs.
- **Reset**: state goes to IDLE and `acc`, `remaining`, `ovf`, `acc_out`, `out_valid` and `in_ready` all go to 0. This applies at any time, including mid-frame or during DONE. The in-flight frame is discarded and no partial result is emitted.

## Timing
- `start` high at cycle t in IDLE: `in_ready`=1 from t+1 (ACCUM). For `len`=0, `out_valid`=1 at t+1.
- Throughput: one product per cycle in ACCUM.
- Last beat accepted at cycle k: the registered sum is visible and `out_valid`=1 at k+1.
- Result taken at cycle m (`out_valid`&`out_ready`): IDLE at m+1, and a new `start` can be accepted at m+1.
- Minimum frame period: `len`+2 cycles.
- The output handshake is sticky: `out_valid` never drops without `out_ready`.

## Configuration
- Macro: `BOOTH_ACC_SAT_EN`.
- **Defined**: on overflow, `acc` clamps to +2^(ACC_W−1)−1 or −2^(ACC_W−1), matching the sign of the addends. It stays clamped until a subsequent addition moves it back inside the range. `ovf` is set.
- **Undefined**: `acc` wraps modulo 2^ACC_W and `ovf` is set.
- Port list is identical in both builds.

## Structure
- Shared package `booth_pkg` holds:
  - `PROD_W` and default `ACC_W`/`LEN_W` constants.
  - The `acc_state_t` enum (IDLE, ACCUM, DONE).
- One sub-module: `booth_acc_add`. It is combinational: sign-extend, add, detect overflow, and saturate under `BOOTH_ACC_SAT_EN`. The FSM, counter and registers stay in the top module.

## Test plan
- **Basic frame**: `len`=3, products 4, 12, −12 back-to-back → `out_valid` one cycle after the third beat, `acc_out`=4, `ovf`=0.
- **Empty frame**: `len`=0 → `out_valid`=1 at t+1, `acc_out`=0, `in_ready` never asserted.
- **Bubbles and backpressure**:
  - `len`=2, products 225 (as 8'hE1 = −31) and 2, with 3 idle cycles between them → `acc_out`=−29.
  - Hold `out_ready`=0 for 5 cycles → `acc_out` stable, `in_ready`=0, and a `start` during DONE is ignored.
- **Overflow** (`ACC_W`=10): 5 × 127.
  - Without the macro → `acc_out`=−389, `ovf`=1.
  - With `BOOTH_ACC_SAT_EN` → `acc_out`=511, `ovf`=1.
- **Reset mid-frame**: assert `rst` after 2 of 4 beats → all outputs 0 immediately. A fresh `len`=1, product −12 frame then yields `acc_out`=−12, `ovf`=0.
